// File: rtl/manch_rx_ctrl.sv
// manch_rx_ctrl: takes bytes from an asynchronous Manchester decoder through
// a dec_ready / dec_rdn handshake and buffers them in a small show-ahead FIFO.
// Optional frame-end timeout is built only when MANCH_RX_TIMEOUT_EN is defined;
// without it frame_end is tied low and no idle counter exists.
module manch_rx_ctrl #(
  parameter int DEPTH       = 4,
  parameter int IDLE_CYCLES = 48
) (
  input  logic                     rst,
  input  logic                     clk16x,
  input  logic                     mdi,
  input  logic [7:0]               dec_dout,
  input  logic                     dec_ready,
  output logic                     dec_rdn,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overrun,
  input  logic                     clr_ovr,
  output logic                     frame_end
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

  state_t state_q, state_d;

  logic rdy_s1, rdy_s2, rdy_d, rise_q;
  logic rdy_rise;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          cap, full, push, pop, drop;

  // dec_ready crosses from the decoder domain; the edge pulse is registered
  // once more so a byte lands in the FIFO on the 4th edge after first sample
  always_ff @(posedge clk16x or posedge rst) begin
    if (rst) begin
      rdy_s1 <= 1'b0;
      rdy_s2 <= 1'b0;
      rdy_d  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      rdy_s1 <= dec_ready;
      rdy_s2 <= rdy_s1;
      rdy_d  <= rdy_s2;
      rise_q <= rdy_rise;
    end
  end

  assign rdy_rise = rdy_s2 & ~rdy_d;

  // handshake state register
  always_ff @(posedge clk16x or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // handshake next state; capture lasts exactly one cycle, ACK holds until
  // the decoder drops dec_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise_q) state_d = CAPTURE;
      CAPTURE: state_d = ACK;
      ACK:     if (!rdy_s2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dec_rdn = (state_q != ACK);

  // FIFO control: a pop frees the slot the concurrent push needs, so a full
  // FIFO only drops when nobody is reading on the capture edge
  assign cap  = (state_q == CAPTURE);
  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = rd_en && (count != '0);
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  // pointers, occupancy and sticky overrun (set beats clear)
  always_ff @(posedge clk16x or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  // storage array; contents are don't-care while unoccupied
  always_ff @(posedge clk16x) begin
    if (push) mem[wr_ptr] <= dec_dout;
  end

  assign rd_valid   = (count != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level = count;

`ifdef MANCH_RX_TIMEOUT_EN
  localparam int CW = $clog2(IDLE_CYCLES + 1);

  logic          mdi_s1, mdi_s2, mdi_d;
  logic [CW-1:0] idle_cnt;
  logic          byte_seen, mdi_edge, fire;

  assign mdi_edge = mdi_s2 ^ mdi_d;
  assign fire     = !mdi_edge && (idle_cnt == CW'(IDLE_CYCLES - 1)) && byte_seen;

  // line idle timer: restarts on any line transition, saturates at the
  // threshold so a long idle line yields a single frame_end
  always_ff @(posedge clk16x or posedge rst) begin
    if (rst) begin
      mdi_s1    <= 1'b0;
      mdi_s2    <= 1'b0;
      mdi_d     <= 1'b0;
      idle_cnt  <= '0;
      byte_seen <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      mdi_s1 <= mdi;
      mdi_s2 <= mdi_s1;
      mdi_d  <= mdi_s2;
      if (mdi_edge)                           idle_cnt <= '0;
      else if (idle_cnt != CW'(IDLE_CYCLES))  idle_cnt <= idle_cnt + 1'b1;
      byte_seen <= cap | (byte_seen & ~fire);
      frame_end <= fire;
    end
  end
`else
  logic unused_mdi;
  assign unused_mdi = mdi;
  assign frame_end  = 1'b0;
`endif

endmodule

// File: tb/tb_manch_rx_ctrl.sv
// tb_manch_rx_ctrl: directed scenarios plus randomized traffic, checked
// against a queue-based model of the receive FIFO and overrun flag.
module tb_manch_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk16x = 1'b0;
  logic          rst, mdi, dec_ready, rd_en, clr_ovr;
  logic [7:0]    dec_dout, rd_data;
  logic          dec_rdn, rd_valid, overrun, frame_end;
  logic [LW-1:0] fifo_level;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         fe_hi   = 0;
  logic [7:0] q[$];
  bit         m_ovr;

  manch_rx_ctrl #(.DEPTH(DEPTH), .IDLE_CYCLES(48)) dut (
    .rst(rst), .clk16x(clk16x), .mdi(mdi), .dec_dout(dec_dout),
    .dec_ready(dec_ready), .dec_rdn(dec_rdn), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level),
    .overrun(overrun), .clr_ovr(clr_ovr), .frame_end(frame_end)
  );

  always #5 clk16x = ~clk16x;

  // frame_end high cycles, sampled mid-cycle
  always @(negedge clk16x) if (frame_end === 1'b1) fe_hi++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk16x);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".valid"}, {31'd0, rd_valid}, (q.size() != 0) ? 1 : 0);
    chk({tag, ".level"}, {{(32-LW){1'b0}}, fifo_level}, q.size());
    chk({tag, ".data"},  {24'd0, rd_data}, (q.size() != 0) ? {24'd0, q[0]} : 0);
    chk({tag, ".ovr"},   {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  task automatic do_reset();
    rst = 1'b1; dec_ready = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    q.delete(); m_ovr = 1'b0;
    tick();
  endtask

  // one full decoder handshake; optional pop / clear on the capture edge
  task automatic send(input logic [7:0] b, input bit pop_at, input bit clr_at, input bit chk_lat);
    int  t;
    bit  dropped;
    dec_dout = b; dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin rd_en = pop_at; clr_ovr = clr_at; end
      tick();
      if (chk_lat && i == 3) begin
        chk("lat.valid_e3", {31'd0, rd_valid}, 0);
        chk("lat.rdn_e3",   {31'd0, dec_rdn}, 1);
      end
    end
    rd_en = 1'b0; clr_ovr = 1'b0;
    dropped = 1'b0;
    if (pop_at && q.size() > 0) void'(q.pop_front());
    if (q.size() < DEPTH) q.push_back(b);
    else begin dropped = 1'b1; m_ovr = 1'b1; end
    if (clr_at && !dropped) m_ovr = 1'b0;
    if (chk_lat) chk("lat.valid_e4", {31'd0, rd_valid}, 1);
    chk("ack_low", {31'd0, dec_rdn}, 0);
    dec_ready = 1'b0;
    t = 0;
    while (dec_rdn !== 1'b1 && t < 20) begin tick(); t++; end
    chk("ack_release", (t < 20) ? 1 : 0, 1);
    tick(); tick();
  endtask

  task automatic pop1();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clr1();
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    int op, fe0;
    rst = 1'b1; mdi = 1'b0; dec_ready = 1'b0; dec_dout = 8'h00;
    rd_en = 1'b0; clr_ovr = 1'b0; m_ovr = 1'b0;
    #3;
    chk("rst.rdn",   {31'd0, dec_rdn}, 1);
    chk("rst.valid", {31'd0, rd_valid}, 0);
    chk("rst.data",  {24'd0, rd_data}, 0);
    chk("rst.level", {{(32-LW){1'b0}}, fifo_level}, 0);
    chk("rst.ovr",   {31'd0, overrun}, 0);
    chk("rst.fe",    {31'd0, frame_end}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single byte, latency and show-ahead
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("s030.data", {24'd0, rd_data}, 32'hA5);
    chk_state("s030");
    pop1();
    chk_state("s030.pop");

    // overfill, then drain in order
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b0, 1'b0, 1'b0);
    chk("s031.level", {{(32-LW){1'b0}}, fifo_level}, 4);
    chk("s031.ovr",   {31'd0, overrun}, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("s031.pop", {24'd0, rd_data}, i);
      pop1();
    end
    chk_state("s031.empty");
    pop1();
    chk_state("s031.pop_empty");

    // push and pop together while full
    clr1();
    for (int b = 1; b <= 4; b++) send(8'(b), 1'b0, 1'b0, 1'b0);
    send(8'h05, 1'b1, 1'b0, 1'b0);
    chk("s032.ovr",   {31'd0, overrun}, 0);
    chk("s032.level", {{(32-LW){1'b0}}, fifo_level}, 4);
    chk("s032.head",  {24'd0, rd_data}, 2);
    chk_state("s032");

    // clear colliding with a drop loses, clear alone wins
    send(8'h66, 1'b0, 1'b1, 1'b0);
    chk("s035.same", {31'd0, overrun}, 1);
    clr1();
    chk("s035.next", {31'd0, overrun}, 0);
    chk_state("s035");

    // asynchronous reset during ACK with two bytes stored
    do_reset();
    send(8'h11, 1'b0, 1'b0, 1'b0);
    dec_dout = 8'h22; dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("s033.pre_rdn",   {31'd0, dec_rdn}, 0);
    chk("s033.pre_level", {{(32-LW){1'b0}}, fifo_level}, 2);
    #2 rst = 1'b1;
    #1;
    chk("s033.rdn",   {31'd0, dec_rdn}, 1);
    chk("s033.level", {{(32-LW){1'b0}}, fifo_level}, 0);
    chk("s033.valid", {31'd0, rd_valid}, 0);
    dec_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    q.delete(); m_ovr = 1'b0;
    tick();
    chk_state("s033.after");

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4)
        send(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
      else if (op <= 7) pop1();
      else if (op == 8) clr1();
      else tick();
      chk_state($sformatf("rnd%0d", i));
    end

`ifdef MANCH_RX_TIMEOUT_EN
    // frame end after a captured byte, none without one
    do_reset();
    mdi = ~mdi; repeat (4) tick();
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    fe0 = fe_hi;
    mdi = ~mdi;
    repeat (100) tick();
    chk("s034.one_pulse", fe_hi - fe0, 1);
    fe0 = fe_hi;
    repeat (100) tick();
    chk("s034.saturated", fe_hi - fe0, 0);
    mdi = ~mdi;
    repeat (100) tick();
    chk("s034.no_byte", fe_hi - fe0, 0);
`else
    fe0 = fe_hi;
    mdi = ~mdi;
    repeat (60) tick();
    chk("no_frame_end", fe_hi, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
